d_cache_assoc: RTL
==================

# d_cache_assoc

Parametrised N-way set-associative write-back, write-allocate data cache between the RISC-V core's data port and the slow 128-bit data memory. It generalises the earlier fixed 2-way/16-set D-cache in three ways: configurable ways and sets, LRU replacement (tree pseudo-LRU for 4 ways), and saturating hit/miss counters for performance measurement. Blocks are fixed at 4 words, matching the 128-bit memory bus.

## Interface
- WAYS, 2: associativity; legal values 2 or 4.
- SETS, 16: number of sets; power of 2, 2..256. IDX_W = log2(SETS).
- ADDR_W, 30: word-address width. TAG_W = ADDR_W-2-IDX_W (24 at defaults).
- CNT_W, 32: width of the performance counters.

- clk  in  1  clock; all logic is rising-edge.
- proc_reset_n  in  1  synchronous, active-low reset.
- proc_read, proc_write  in  1 each  request strobes; held stable while proc_stall=1.
- proc_addr  in  ADDR_W  word address: [1:0] word, [IDX_W+1:2] index, upper bits tag.
- proc_wdata  in  32  store data.
- proc_stall  out  1  core must hold the request.
- proc_rdata  out  32  load data; valid when a read request has proc_stall=0.
- mem_read, mem_write  out  1 each  memory request strobes.
- mem_addr  out  ADDR_W-2  block address {tag, index}.
- mem_wdata  out  128  write-back line.
- mem_rdata  in  128  refill line; sampled when mem_ready=1.
- mem_ready  in  1  one-cycle completion pulse.
- hit_cnt, miss_cnt  out  CNT_W each  saturating counters.

## Operation
- Per line: valid, dirty, tag, 128-bit data. Per set: LRU state (1 bit for WAYS=2; 3-bit tree PLRU for WAYS=4).
- Reset clears all valid, dirty and LRU bits, the counters and the FSM (→IDLE); tag and data arrays are not reset. Every output is 0 during and immediately after reset.
- Requests with both strobes high are treated as writes.
- FSM states: IDLE, WB, ALLOC.
- IDLE, no request: proc_stall=0, no state change.
- IDLE hit (valid && tag match in some way): proc_stall=0 combinationally; proc_rdata is the selected word of the hitting way. On a write, the word is updated and dirty is set at the clock edge. LRU is updated to mark the hit way most-recent.
- IDLE miss: proc_stall=1 combinationally.
  - Choose the victim: the lowest-index invalid way, otherwise the LRU way.
  - Latch the victim way, the victim address {victim tag, index}, the victim data and the request address.
  - Next state is WB if the victim is valid and dirty, otherwise ALLOC. miss_cnt increments.
- WB: mem_write=1, mem_addr=victim block address, mem_wdata=victim line, proc_stall=1. On mem_ready the victim's dirty bit is cleared and the FSM goes to ALLOC.
- ALLOC: mem_read=1, mem_addr={request tag, index}, proc_stall=1. On mem_ready, mem_rdata is written into the victim way with valid=1, dirty=0 and tag set; the FSM goes to IDLE.
- In the first IDLE cycle after ALLOC the held request hits and is served like any hit (a write sets dirty). This post-refill hit does not increment hit_cnt. Every other IDLE hit increments hit_cnt.
- Counters saturate at 2^CNT_W-1.
- Memory strobes and mem_addr/mem_wdata are decoded from registered state and latched data, so they are glitch-free.

## Timing
- Hit: 0-cycle latency; the request completes in the cycle it is presented.
- Clean miss presented in cycle 0:
  - mem_read=1 from cycle 1 until the mem_ready cycle k.
  - mem_read=0 and proc_stall=0 in cycle k+1, when the data is served.
- Dirty miss: mem_write runs from cycle 1 through mem_ready at j. mem_read runs from j+1 through mem_ready at k. The request is served at k+1.
- mem_read and mem_write are never high together. Each strobe drops the cycle after its mem_ready.
- mem_ready outside WB/ALLOC is ignored.
- Reset mid-WB/ALLOC: the strobes are 0 in the cycle after the reset edge, and in-flight dirty data is discarded.

## Test plan
- Reset, then read addr 0x00000040: stall for one memory transaction; mem_addr=0x0000010; returned line word0=0x11111111 → proc_rdata=0x11111111; miss_cnt=1, hit_cnt=0.
- Write 0xDEADBEEF to 0x41, then read 0x41 → both complete with stall=0, read returns 0xDEADBEEF; hit_cnt=2.
- WAYS=2: fill index 0 with tags A and B, touch A, then miss on tag C → the B line is evicted (no write-back since clean); a subsequent read of A hits.
- Dirty victim: write to tag A, fill B, touch B, miss on C → mem_write with mem_addr={A,0} and the written word in mem_wdata. This is followed by mem_read with {C,0}; the strobes never overlap.
- WAYS=4, SETS=64: access 5 distinct tags in set 3 → the 5th access evicts the PLRU way; 4 misses fill the invalid ways first, in order 0,1,2,3.
- Assert proc_reset_n=0 during ALLOC → the next cycle has mem_read=0, proc_stall=0 and counters 0; a later read of the old address misses.

Source files
------------

// File: rtl/d_cache_assoc.sv
// N-way set-associative write-back / write-allocate data cache with 4-word lines,
// pseudo-LRU replacement and saturating hit/miss counters.
module d_cache_assoc #(
  parameter int WAYS   = 2,
  parameter int SETS   = 16,
  parameter int ADDR_W = 30,
  parameter int CNT_W  = 32
) (
  input  logic                clk,
  input  logic                proc_reset_n,
  input  logic                proc_read,
  input  logic                proc_write,
  input  logic [ADDR_W-1:0]   proc_addr,
  input  logic [31:0]         proc_wdata,
  output logic                proc_stall,
  output logic [31:0]         proc_rdata,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-3:0]   mem_addr,
  output logic [127:0]        mem_wdata,
  input  logic [127:0]        mem_rdata,
  input  logic                mem_ready,
  output logic [CNT_W-1:0]    hit_cnt,
  output logic [CNT_W-1:0]    miss_cnt
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;
  localparam int WAY_W = $clog2(WAYS);
  localparam int LRU_W = WAYS - 1;

  typedef enum logic [1:0] {S_IDLE, S_WB, S_ALLOC} state_e;

  state_e                 state_q, state_d;
  logic [WAYS-1:0]        valid_q [SETS];
  logic [WAYS-1:0]        valid_d [SETS];
  logic [WAYS-1:0]        dirty_q [SETS];
  logic [WAYS-1:0]        dirty_d [SETS];
  logic [LRU_W-1:0]       lru_q   [SETS];
  logic [LRU_W-1:0]       lru_d   [SETS];
  logic [TAG_W-1:0]       tag_q   [SETS][WAYS];
  logic [TAG_W-1:0]       tag_d   [SETS][WAYS];
  logic [127:0]           data_q  [SETS][WAYS];
  logic [127:0]           data_d  [SETS][WAYS];

  logic [WAY_W-1:0]       victim_way_q, victim_way_d;
  logic [ADDR_W-3:0]      victim_addr_q, victim_addr_d;
  logic [127:0]           victim_data_q, victim_data_d;
  logic [ADDR_W-3:0]      req_blk_q, req_blk_d;
  logic                   refill_q, refill_d;
  logic [CNT_W-1:0]       hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]       miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0]       idx, req_idx;
  logic [TAG_W-1:0]       tag, req_tag;
  logic [1:0]             word;
  logic                   is_req;
  logic                   hit;
  logic [WAY_W-1:0]       hit_way;
  logic                   have_inv;
  logic [WAY_W-1:0]       inv_way;
  logic [WAY_W-1:0]       victim_way;
  logic                   stall;
  logic [31:0]            rdata;

  // 2 ways: one bit holding the most-recent way. 4 ways: tree {b2, b1, b0},
  // b0 selects the LRU half, b1/b2 the LRU way within halves {0,1}/{2,3}.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [LRU_W-1:0] bits);
    logic [2:0] t;
    logic [1:0] v;
    t = 3'(bits);
    if (WAYS == 2) v = {1'b0, ~t[0]};
    else           v = t[0] ? {1'b1, t[2]} : {1'b0, t[1]};
    return v[WAY_W-1:0];
  endfunction

  function automatic logic [LRU_W-1:0] plru_touch(input logic [LRU_W-1:0] bits,
                                                  input logic [WAY_W-1:0] way);
    logic [2:0] t;
    logic [1:0] w;
    t = 3'(bits);
    w = 2'(way);
    if (WAYS == 2) begin
      t[0] = w[0];
    end else begin
      t[0] = ~w[1];
      if (w[1]) t[2] = ~w[0];
      else      t[1] = ~w[0];
    end
    return t[LRU_W-1:0];
  endfunction

  assign is_req  = proc_read | proc_write;
  assign word    = proc_addr[1:0];
  assign idx     = proc_addr[IDX_W+1:2];
  assign tag     = proc_addr[ADDR_W-1:IDX_W+2];
  assign req_idx = req_blk_q[IDX_W-1:0];
  assign req_tag = req_blk_q[ADDR_W-3:IDX_W];

  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    have_inv = 1'b0;
    inv_way  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) begin
        have_inv = 1'b1;
        inv_way  = WAY_W'(w);
      end
    end
    victim_way = have_inv ? inv_way : plru_victim(lru_q[idx]);
  end

  // NOTE: every variable gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    dirty_d       = dirty_q;
    lru_d         = lru_q;
    tag_d         = tag_q;
    data_d        = data_q;
    victim_way_d  = victim_way_q;
    victim_addr_d = victim_addr_q;
    victim_data_d = victim_data_q;
    req_blk_d     = req_blk_q;
    refill_d      = 1'b0;
    hit_cnt_d     = hit_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    stall         = 1'b0;
    rdata         = '0;
    unique case (state_q)
      S_IDLE: begin
        if (is_req && hit) begin
          rdata = data_q[idx][hit_way][{word, 5'd0} +: 32];
          if (proc_write) begin
            data_d[idx][hit_way][{word, 5'd0} +: 32] = proc_wdata;
            dirty_d[idx][hit_way] = 1'b1;
          end
          lru_d[idx] = plru_touch(lru_q[idx], hit_way);
          if (!refill_q && hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end else if (is_req) begin
          stall         = 1'b1;
          victim_way_d  = victim_way;
          victim_addr_d = {tag_q[idx][victim_way], idx};
          victim_data_d = data_q[idx][victim_way];
          req_blk_d     = proc_addr[ADDR_W-1:2];
          state_d = (valid_q[idx][victim_way] && dirty_q[idx][victim_way]) ? S_WB : S_ALLOC;
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
        end
      end
      S_WB: begin
        stall = 1'b1;
        if (mem_ready) begin
          dirty_d[req_idx][victim_way_q] = 1'b0;
          state_d = S_ALLOC;
        end
      end
      S_ALLOC: begin
        stall = 1'b1;
        if (mem_ready) begin
          data_d[req_idx][victim_way_q]  = mem_rdata;
          tag_d[req_idx][victim_way_q]   = req_tag;
          valid_d[req_idx][victim_way_q] = 1'b1;
          dirty_d[req_idx][victim_way_q] = 1'b0;
          refill_d = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!proc_reset_n) begin
      state_q    <= S_IDLE;
      refill_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        lru_q[s]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      refill_q   <= refill_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      lru_q      <= lru_d;
    end
  end

  // NOTE: tag/data arrays and miss latches stay unreset; valid bits and state gate their use.
  always_ff @(posedge clk) begin
    tag_q         <= tag_d;
    data_q        <= data_d;
    victim_way_q  <= victim_way_d;
    victim_addr_q <= victim_addr_d;
    victim_data_q <= victim_data_d;
    req_blk_q     <= req_blk_d;
  end

  assign proc_stall = proc_reset_n && stall;
  assign proc_rdata = proc_reset_n ? rdata : '0;
  assign mem_write  = proc_reset_n && (state_q == S_WB);
  assign mem_read   = proc_reset_n && (state_q == S_ALLOC);
  assign mem_addr   = !proc_reset_n         ? '0 :
                      (state_q == S_WB)     ? victim_addr_q :
                      (state_q == S_ALLOC)  ? req_blk_q : '0;
  assign mem_wdata  = (proc_reset_n && state_q == S_WB) ? victim_data_q : '0;
  assign hit_cnt    = proc_reset_n ? hit_cnt_q : '0;
  assign miss_cnt   = proc_reset_n ? miss_cnt_q : '0;

endmodule
